// File: rtl/imm_extend_pipe.sv
// Pipelined RV immediate extender: output register plus one skid entry behind valid/ready.
// Define IMM_EXTEND_PIPE_ILLEGAL_EN to add illegal_o / illegal_cnt reporting of ImmSrc 110/111.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
  output logic             illegal_o,
  output logic [15:0]      illegal_cnt,
`endif
  output logic [1:0]       dbg_state_o
);

  // Handshake: a word moves when valid && ready are both high at a rising edge;
  // a producer holding valid keeps its payload stable until it is taken.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]  imm_in;
  logic [31:0]      v32;
  logic             accept;
  logic             or_load_new, or_load_sk, sk_load;
  logic [XLEN-1:0]  or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;

  // instr[k] holds instruction bit k+7, so instruction bit 31 is instr[24].
  always_comb begin
    v32 = 32'h0;
    case (ImmSrc)
      3'b000:  v32 = {{20{instr[24]}}, instr[24:13]};
      3'b001:  v32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      3'b010:  v32 = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      3'b011:  v32 = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      3'b100:  v32 = {instr[24:5], 12'h000};
      3'b101:  v32 = {27'h0, instr[12:8]};
      default: v32 = 32'h0;
    endcase
    // Every 32-bit form above is already sign-correct, so widening is a plain sign extension.
    imm_in = XLEN'($signed(v32));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_valid) state_d = ST_ONE;
        ST_ONE: begin
          if (in_valid && !out_ready)      state_d = ST_FULL;
          else if (!in_valid && out_ready) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_ready) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready depends only on registered state, never on out_ready.
  always_comb begin
    in_ready    = (state_q != ST_FULL);
    out_valid   = (state_q != ST_EMPTY);
    dbg_state_o = state_q;
    accept      = in_valid && in_ready && !flush;
    or_load_new = accept && ((state_q == ST_EMPTY) || (state_q == ST_ONE && out_ready));
    sk_load     = accept && (state_q == ST_ONE) && !out_ready;
    or_load_sk  = !flush && (state_q == ST_FULL) && out_ready;
  end

  always_comb begin
    or_imm_d = or_imm_q;
    or_tag_d = or_tag_q;
    sk_imm_d = sk_imm_q;
    sk_tag_d = sk_tag_q;
    if (or_load_new) begin
      or_imm_d = imm_in;
      or_tag_d = in_tag;
    end else if (or_load_sk) begin
      or_imm_d = sk_imm_q;
      or_tag_d = sk_tag_q;
    end
    if (sk_load) begin
      sk_imm_d = imm_in;
      sk_tag_d = in_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      or_imm_q <= '0;
      or_tag_q <= '0;
      sk_imm_q <= '0;
      sk_tag_q <= '0;
    end else begin
      or_imm_q <= or_imm_d;
      or_tag_q <= or_tag_d;
      sk_imm_q <= sk_imm_d;
      sk_tag_q <= sk_tag_d;
    end
  end

  assign ImmExt  = or_imm_q;
  assign out_tag = or_tag_q;

`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
  logic        illegal_in;
  logic        or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
  logic [15:0] cnt_q, cnt_d;

  assign illegal_in = (ImmSrc[2:1] == 2'b11);

  always_comb begin
    or_ill_d = or_ill_q;
    sk_ill_d = sk_ill_q;
    cnt_d    = cnt_q;
    if (or_load_new)     or_ill_d = illegal_in;
    else if (or_load_sk) or_ill_d = sk_ill_q;
    if (sk_load)         sk_ill_d = illegal_in;
    // Flush does not clear the count; only entries actually taken in are counted.
    if (accept && illegal_in && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      or_ill_q <= 1'b0;
      sk_ill_q <= 1'b0;
      cnt_q    <= 16'h0;
    end else begin
      or_ill_q <= or_ill_d;
      sk_ill_q <= sk_ill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign illegal_o   = or_ill_q;
  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [24:0] instr;
  logic [2:0]  ImmSrc;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
  logic [1:0]  st32, st64;
`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
  logic        ill32, ill64;
  logic [15:0] cnt32, cnt64;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExt(imm32), .out_tag(tag32),
`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
    .illegal_o(ill32), .illegal_cnt(cnt32),
`endif
    .dbg_state_o(st32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExt(imm64), .out_tag(tag64),
`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
    .illegal_o(ill64), .illegal_cnt(cnt64),
`endif
    .dbg_state_o(st64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] raw, input logic [2:0] src, input logic [4:0] tag);
    in_valid = 1'b1;
    instr    = raw[31:7];
    ImmSrc   = src;
    in_tag   = tag;
  endtask

  // One accepted word with out_ready=1, checked on the cycle right after acceptance.
  task automatic vec(input string name, input logic [31:0] raw, input logic [2:0] src,
                     input logic [4:0] tag, input logic [31:0] e32, input logic [63:0] e64);
    drive(raw, src, tag);
    tick();
    check({name, "_valid"}, {63'h0, out_valid32}, 64'h1);
    check({name, "_imm32"}, {32'h0, imm32}, {32'h0, e32});
    check({name, "_imm64"}, imm64, e64);
    check({name, "_tag"}, {59'h0, tag32}, {59'h0, tag});
    check({name, "_tag64"}, {59'h0, tag64}, {59'h0, tag});
  endtask

  task automatic check_handshake(input string name, input logic ov, input logic ir, input logic [1:0] st);
    check({name, "_out_valid"}, {63'h0, out_valid32}, {63'h0, ov});
    check({name, "_in_ready"}, {63'h0, in_ready32}, {63'h0, ir});
    check({name, "_state"}, {62'h0, st32}, {62'h0, st});
    check({name, "_out_valid64"}, {63'h0, out_valid64}, {63'h0, ov});
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    instr = '0; ImmSrc = '0; in_tag = '0; out_ready = 1'b0;
    #3;
    check_handshake("reset", 1'b0, 1'b1, 2'd0);
    check("reset_imm32", {32'h0, imm32}, 64'h0);
    check("reset_imm64", imm64, 64'h0);
    check("reset_tag", {59'h0, tag32}, 64'h0);

    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    // Format vectors back to back; first one accepted on the first edge after reset release.
    vec("addi_m1", 32'hFFF00093, 3'b000, 5'd3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    vec("beq_m4",  32'hFE000EE3, 3'b010, 5'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    vec("lui_neg", 32'h800000B7, 3'b100, 5'd5, 32'h80000000, 64'hFFFFFFFF80000000);
    vec("lui_pos", 32'h123450B7, 3'b100, 5'd6, 32'h12345000, 64'h0000000012345000);
    vec("sw_m4",   32'hFE112E23, 3'b001, 5'd7, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    vec("jal_p8",  32'h0080006F, 3'b011, 5'd8, 32'h00000008, 64'h0000000000000008);
    vec("jal_m2",  32'hFFFFF06F, 3'b011, 5'd9, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE);
    vec("csr_z",   32'hFFFFFFFF, 3'b101, 5'd10, 32'h0000001F, 64'h000000000000001F);
    vec("ill_110", 32'hFFFFFFFF, 3'b110, 5'd11, 32'h0, 64'h0);
    vec("ill_111", 32'hFFFFFFFF, 3'b111, 5'd12, 32'h0, 64'h0);
    check_handshake("stream", 1'b1, 1'b1, 2'd1);

    in_valid = 1'b0;
    tick();
    check_handshake("drained", 1'b0, 1'b1, 2'd0);

    // Back-pressure: two words fill OR and SK, then drain in order.
    out_ready = 1'b0;
    drive(32'h00100093, 3'b000, 5'd1);
    tick();
    check_handshake("bp_one", 1'b1, 1'b1, 2'd1);
    drive(32'h00200093, 3'b000, 5'd2);
    tick();
    check_handshake("bp_full", 1'b1, 1'b0, 2'd2);
    check("bp_full_tag", {59'h0, tag32}, 64'd1);
    check("bp_full_imm", {32'h0, imm32}, 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_hold_tag", {59'h0, tag32}, 64'd1);
    check("bp_hold_imm", {32'h0, imm32}, 64'd1);
    check("bp_hold_ready", {63'h0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    tick();
    check_handshake("bp_sk_move", 1'b1, 1'b1, 2'd1);
    check("bp_second_tag", {59'h0, tag32}, 64'd2);
    check("bp_second_imm", {32'h0, imm32}, 64'd2);
    tick();
    check_handshake("bp_empty", 1'b0, 1'b1, 2'd0);

    // Flush while FULL with a word offered.
    out_ready = 1'b0;
    drive(32'h00400093, 3'b000, 5'd4);
    tick();
    drive(32'h00500093, 3'b000, 5'd5);
    tick();
    check_handshake("fl_full", 1'b1, 1'b0, 2'd2);
    drive(32'h00600093, 3'b000, 5'd6);
    flush = 1'b1;
    tick();
    check_handshake("fl_after", 1'b0, 1'b1, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_handshake("fl_nothing", 1'b0, 1'b1, 2'd0);

    // Flush in ONE with a same-cycle accept: the new word must be discarded too.
    out_ready = 1'b0;
    drive(32'h00700093, 3'b000, 5'd7);
    tick();
    drive(32'h00800093, 3'b000, 5'd8);
    flush = 1'b1;
    tick();
    check_handshake("fl_one", 1'b0, 1'b1, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_handshake("fl_one_next", 1'b0, 1'b1, 2'd0);

    // Asynchronous reset in the middle of a FULL buffer.
    out_ready = 1'b0;
    drive(32'h00900093, 3'b000, 5'd9);
    tick();
    drive(32'h00A00093, 3'b000, 5'd10);
    tick();
    check_handshake("rst_pre", 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_handshake("rst_async", 1'b0, 1'b1, 2'd0);
    check("rst_async_imm32", {32'h0, imm32}, 64'h0);
    check("rst_async_imm64", imm64, 64'h0);
    check("rst_async_tag", {59'h0, tag32}, 64'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    vec("post_rst", 32'h7FF00093, 3'b000, 5'd11, 32'h000007FF, 64'h00000000000007FF);

`ifdef IMM_EXTEND_PIPE_ILLEGAL_EN
    vec("cnt_ill_a", 32'h12345678, 3'b111, 5'd20, 32'h0, 64'h0);
    check("ill_flag_a", {63'h0, ill32}, 64'd1);
    vec("cnt_ill_b", 32'hFFFFFFFF, 3'b111, 5'd21, 32'h0, 64'h0);
    check("ill_flag_b", {63'h0, ill32}, 64'd1);
    vec("cnt_ill_c", 32'h80000000, 3'b111, 5'd22, 32'h0, 64'h0);
    check("ill_flag_c", {63'h0, ill64}, 64'd1);
    check("ill_cnt3", {48'h0, cnt32}, 64'd3);
    vec("legal_after", 32'h00100093, 3'b000, 5'd23, 32'h1, 64'h1);
    check("ill_flag_clear", {63'h0, ill32}, 64'd0);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    check("ill_cnt_flush", {48'h0, cnt32}, 64'd3);
    check("ill_cnt_flush64", {48'h0, cnt64}, 64'd3);
`endif

    in_valid = 1'b0;
    tick();
    check_handshake("final", 1'b0, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender in the decode stage.
- Takes instr[31:7] plus an ImmSrc selector and produces an XLEN-wide immediate.
- Registered output behind a valid/ready handshake, with a 2-entry skid buffer, flush support and a tag passthrough.
- Sits between instruction fetch/decode and the ID/EX register, so decode back-pressure never drops or reorders immediates.

Parameters:
- XLEN, 32, output width; legal values 32 or 64; all sign/zero extension targets XLEN.
- TAG_W, 5, width of the opaque sideband tag (e.g. rd index) carried alongside each immediate.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush; discards all buffered entries
- in_valid  input  1  instr/ImmSrc/tag are valid this cycle
- in_ready  output  1  block can accept an entry this cycle
- instr  input  25  instruction bits [31:7]
- ImmSrc  input  3  immediate format select
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  ImmExt/out_tag are valid
- out_ready  input  1  consumer accepts this cycle
- ImmExt  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag matching ImmExt

Behaviour:
- Reset (reset_n low, async):
  - out_valid=0, in_ready=1, ImmExt=0, out_tag=0, both buffer entries invalid.
  - Reset asserted mid-transfer drops all entries.
  - First accept is possible in the first clk edge after deassertion.
- ImmSrc decode (sign bit instr[31] replicated to XLEN unless stated):
  - 000 I: {instr[31:20]}
  - 001 S: {instr[31:25],instr[11:7]}
  - 010 B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - 011 J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
  - 100 U: {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64
  - 101 Z (CSR uimm): zero-extended instr[19:15]
  - 110/111: illegal; ImmExt=0
- Handshake:
  - Accept on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible on ImmExt/out_valid after edge N when the output register was empty or drained at N.
- Buffering:
  - Output register (OR) plus skid register (SK).
  - in_ready is registered and equals !SK.valid; no combinational path from out_ready to in_ready.
  - States: EMPTY (OR,SK invalid), ONE (OR valid), FULL (OR,SK valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !out_ready -> FULL (new entry in SK); accept & out_ready -> ONE (OR reloaded); !accept & out_ready -> EMPTY.
  - FULL: in_ready=0; out_ready -> ONE (SK moves to OR the same edge).
  - Output order always equals input order. While out_valid=1 and out_ready=0, ImmExt and out_tag hold stable.
- Flush:
  - At the edge where flush=1, OR and SK are invalidated; any same-cycle accept is discarded.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush has priority over every other event.

Optional Feature:
- Macro IMM_EXTEND_PIPE_ILLEGAL_EN.
- Defined:
  - Adds output illegal_o (1 bit), registered and aligned with ImmExt; high when the entry's ImmSrc was 110/111.
  - Adds output illegal_cnt (16 bit): saturating count of accepted illegal entries; reset to 0 by reset_n only, not by flush.
- Undefined: ports are absent; illegal codes still yield ImmExt=0.

Test Plan:
- XLEN=32, instr=0xFFF00093>>7, ImmSrc=000, out_ready=1 -> one cycle later out_valid=1, ImmExt=0xFFFFFFFF.
- XLEN=32, instr=0xFE000EE3>>7 (beq -4), ImmSrc=010 -> ImmExt=0xFFFFFFFC.
- U-type: instr=0x800000B7>>7, ImmSrc=100.
  - XLEN=64 -> ImmExt=0xFFFFFFFF80000000.
  - instr=0x123450B7>>7 -> ImmExt=0x0000000012345000.
- Back-pressure: hold out_ready=0, push tags 1,2 -> in_ready=0 after the second accept, ImmExt stable on tag 1. Release out_ready -> tags 1 then 2 emitted in order, in_ready=1 one cycle after SK drains.
- In FULL, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emitted. Assert reset_n=0 mid-stream -> all outputs 0 immediately, no clk edge needed.
- With IMM_EXTEND_PIPE_ILLEGAL_EN defined: send ImmSrc=111 three times -> ImmExt=0 and illegal_o=1 on each, illegal_cnt=3; after a flush, illegal_cnt is still 3.
